// File: rtl/gfx256_mem_arbiter_if.sv
// Requester-side and bus-master-side signals of the gfx256 memory arbiter.
// The arbiter uses the slave view; the surrounding fabric uses the master view.
interface gfx256_mem_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]     req_i;
    logic [NREQ-1:0]     we_i;
    logic [NREQ*32-1:0]  adr_i;
    logic [NREQ*32-1:0]  sel_i;
    logic [NREQ*256-1:0] dat_i;
    logic [NREQ-1:0]     ack_o;
    logic [NREQ-1:0]     err_o;
    logic [255:0]        dat_o;
    logic                read_request_o;
    logic                write_request_o;
    logic [31:0]         mem_adr_o;
    logic [31:0]         mem_sel_o;
    logic [255:0]        mem_dat_o;
    logic [255:0]        mem_dat_i;
    logic                mem_ack_i;
    logic                busy_o;
    logic [2:0]          gnt_o;

    modport slave (
        input  req_i, we_i, adr_i, sel_i, dat_i, mem_dat_i, mem_ack_i,
        output ack_o, err_o, dat_o, read_request_o, write_request_o,
        output mem_adr_o, mem_sel_o, mem_dat_o, busy_o, gnt_o
    );

    modport master (
        output req_i, we_i, adr_i, sel_i, dat_i, mem_dat_i, mem_ack_i,
        input  ack_o, err_o, dat_o, read_request_o, write_request_o,
        input  mem_adr_o, mem_sel_o, mem_dat_o, busy_o, gnt_o
    );
endinterface

// File: rtl/gfx256_mem_arbiter.sv
// Round-robin arbiter sharing one gfx256 bus master port between NREQ
// requesters, with a post-ack guard cycle and a WAIT watchdog.
module gfx256_mem_arbiter #(
    parameter int          NREQ    = 4,
    parameter logic [15:0] TIMEOUT = 16'd1023
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    gfx256_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        GUARD
    } state_e;

    state_e state_q, state_d;

    logic [2:0]      last_q, last_d;
    logic [2:0]      gnt_q, gnt_d;
    logic            we_q, we_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     sel_q, sel_d;
    logic [255:0]    mdat_q, mdat_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] err_q, err_d;
    logic [255:0]    rdat_q, rdat_d;

    logic            timeout;
    logic            win_found;
    logic [2:0]      win_idx;
    logic [NREQ-1:0] req_sh;
    int              idx;

    logic [NREQ-1:0]     we_sh;
    logic [NREQ*32-1:0]  adr_sh;
    logic [NREQ*32-1:0]  sel_sh;
    logic [NREQ*256-1:0] dat_sh;

    assign timeout = (cnt_q == TIMEOUT - 16'd1);

    // First requesting index after the last winner, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        req_sh    = '0;
        idx       = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx    = (int'(last_q) + i) % NREQ;
            req_sh = bus.req_i >> idx;
            if (!win_found && req_sh[0]) begin
                win_found = 1'b1;
                win_idx   = 3'(idx);
            end
        end
    end

    always_comb begin
        we_sh  = bus.we_i >> win_idx;
        adr_sh = bus.adr_i >> {win_idx, 5'd0};
        sel_sh = bus.sel_i >> {win_idx, 5'd0};
        dat_sh = bus.dat_i >> {win_idx, 8'd0};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (win_found) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT:  if (bus.mem_ack_i || timeout) state_d = GUARD;
            GUARD: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_d = last_q;
        gnt_d  = gnt_q;
        we_d   = we_q;
        adr_d  = adr_q;
        sel_d  = sel_q;
        mdat_d = mdat_q;
        cnt_d  = cnt_q;
        ack_d  = '0;
        err_d  = '0;
        rdat_d = rdat_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    last_d = win_idx;
                    gnt_d  = win_idx;
                    we_d   = we_sh[0];
                    adr_d  = adr_sh[31:0];
                    sel_d  = sel_sh[31:0];
                    mdat_d = dat_sh[255:0];
                end
            end
            ISSUE: cnt_d = '0;
            WAIT: begin
                cnt_d = cnt_q + 16'd1;
                // A real ack always beats the watchdog in the same cycle.
                if (bus.mem_ack_i) begin
                    rdat_d = bus.mem_dat_i;
                    ack_d  = NREQ'(1) << gnt_q;
                end else if (timeout) begin
                    rdat_d = '0;
                    ack_d  = NREQ'(1) << gnt_q;
                    err_d  = NREQ'(1) << gnt_q;
                end
            end
            GUARD: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 3'(NREQ - 1);
            gnt_q  <= '0;
            we_q   <= 1'b0;
            adr_q  <= '0;
            sel_q  <= '0;
            mdat_q <= '0;
            cnt_q  <= '0;
            ack_q  <= '0;
            err_q  <= '0;
            rdat_q <= '0;
        end else begin
            last_q <= last_d;
            gnt_q  <= gnt_d;
            we_q   <= we_d;
            adr_q  <= adr_d;
            sel_q  <= sel_d;
            mdat_q <= mdat_d;
            cnt_q  <= cnt_d;
            ack_q  <= ack_d;
            err_q  <= err_d;
            rdat_q <= rdat_d;
        end
    end

    always_comb begin
        bus.busy_o          = (state_q != IDLE);
        bus.read_request_o  = (state_q == ISSUE) && !we_q;
        bus.write_request_o = (state_q == ISSUE) && we_q;
        bus.ack_o           = ack_q;
        bus.err_o           = err_q;
        bus.dat_o           = rdat_q;
        bus.gnt_o           = gnt_q;
        bus.mem_adr_o       = adr_q;
        bus.mem_sel_o       = sel_q;
        bus.mem_dat_o       = mdat_q;
    end

endmodule

// File: tb/tb_gfx256_mem_arbiter.sv
// Directed bench for gfx256_mem_arbiter (NREQ=4, TIMEOUT=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_gfx256_mem_arbiter;

    localparam int NREQ = 4;

    logic clk;
    logic rst_ni;
    int   passed;
    int   failed;
    int   total;
    logic found;
    int   e;

    gfx256_mem_arbiter_if #(.NREQ(NREQ)) bus ();

    gfx256_mem_arbiter #(
        .NREQ   (NREQ),
        .TIMEOUT(16'd8)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        passed = 0;
        failed = 0;
        total  = 0;
        clk    = 1'b0;
        rst_ni = 1'b0;
        bus.req_i     = '0;
        bus.we_i      = '0;
        bus.adr_i     = '0;
        bus.sel_i     = '0;
        bus.dat_i     = '0;
        bus.mem_dat_i = '0;
        bus.mem_ack_i = 1'b0;
        repeat (2) tick();

        chk("rst_busy", bus.busy_o, 0);
        chk("rst_gnt", bus.gnt_o, 0);
        chk("rst_ack", bus.ack_o, 0);
        chk("rst_rdreq", bus.read_request_o, 0);
        chk("rst_dat", bus.dat_o, 0);
        rst_ni = 1'b1;
        tick();
        chk("idle_busy", bus.busy_o, 0);

        // Single read from requester 2
        bus.adr_i[64 +: 32] = 32'h0000_1040;
        bus.req_i = 4'b0100;
        bus.mem_dat_i = 256'h1111_2222;
        tick();
        chk("rd_req", bus.read_request_o, 1);
        chk("rd_wrreq", bus.write_request_o, 0);
        chk("rd_gnt", bus.gnt_o, 2);
        chk("rd_adr", bus.mem_adr_o, 32'h0000_1040);
        tick();
        chk("rd_req_drop", bus.read_request_o, 0);
        tick();
        tick();
        bus.mem_ack_i = 1'b1;
        tick();
        chk("rd_ack", bus.ack_o, 4'b0100);
        chk("rd_dat", bus.dat_o, 256'h1111_2222);
        chk("rd_err", bus.err_o, 0);
        bus.mem_ack_i = 1'b0;
        bus.req_i = 4'b0001;
        bus.adr_i[0 +: 32] = 32'h0000_0080;
        tick();
        chk("guard_ack_pulse", bus.ack_o, 0);
        chk("guard_no_req", bus.read_request_o, 0);
        chk("guard_idle", bus.busy_o, 0);
        tick();
        chk("wrap_gnt", bus.gnt_o, 0);
        chk("wrap_req", bus.read_request_o, 1);
        bus.mem_ack_i = 1'b1;
        tick();
        chk("issue_ack_ignored", bus.ack_o, 0);
        bus.mem_ack_i = 1'b0;
        tick();
        bus.mem_ack_i = 1'b1;
        bus.mem_dat_i = 256'h3333;
        tick();
        chk("wrap_ack", bus.ack_o, 4'b0001);
        chk("wrap_dat", bus.dat_o, 256'h3333);
        bus.mem_ack_i = 1'b0;
        bus.req_i = '0;
        tick();

        // Write pass-through from requester 1
        bus.req_i = 4'b0010;
        bus.we_i  = 4'b0010;
        bus.sel_i[32 +: 32] = 32'h0000_000F;
        bus.sel_i[0 +: 32]  = 32'hFFFF_FFFF;
        bus.dat_i[256 +: 256] = 256'hA5;
        bus.mem_dat_i = 256'hDEAD;
        tick();
        chk("wr_req", bus.write_request_o, 1);
        chk("wr_rdreq", bus.read_request_o, 0);
        chk("wr_gnt", bus.gnt_o, 1);
        chk("wr_sel", bus.mem_sel_o, 32'h0000_000F);
        chk("wr_dat", bus.mem_dat_o, 256'hA5);
        bus.dat_i[256 +: 256] = '0;
        bus.sel_i[32 +: 32] = '0;
        tick();
        chk("wr_req_drop", bus.write_request_o, 0);
        chk("wr_sel_wait", bus.mem_sel_o, 32'h0000_000F);
        chk("wr_dat_wait", bus.mem_dat_o, 256'hA5);
        bus.mem_ack_i = 1'b1;
        tick();
        chk("wr_ack", bus.ack_o, 4'b0010);
        chk("wr_dat_guard", bus.mem_dat_o, 256'hA5);
        chk("wr_sel_guard", bus.mem_sel_o, 32'h0000_000F);
        bus.mem_ack_i = 1'b0;
        bus.req_i = '0;
        bus.we_i  = '0;
        tick();
        chk("wr_done_idle", bus.busy_o, 0);

        // Watchdog on requester 2, requester 3 waiting behind it
        bus.req_i = 4'b1100;
        tick();
        chk("to_gnt", bus.gnt_o, 2);
        repeat (7) tick();
        tick();
        chk("to_wait8_noack", bus.ack_o, 0);
        chk("to_wait8_busy", bus.busy_o, 1);
        tick();
        chk("to_ack", bus.ack_o, 4'b0100);
        chk("to_err", bus.err_o, 4'b0100);
        chk("to_dat", bus.dat_o, 0);
        bus.req_i = 4'b1000;
        tick();
        chk("to_err_pulse", bus.err_o, 0);
        tick();
        chk("next_gnt", bus.gnt_o, 3);
        chk("next_req", bus.read_request_o, 1);

        // Ack on the exact timeout cycle
        repeat (7) tick();
        tick();
        bus.mem_ack_i = 1'b1;
        bus.mem_dat_i = 256'hBEEF;
        tick();
        chk("col_ack", bus.ack_o, 4'b1000);
        chk("col_err", bus.err_o, 0);
        chk("col_dat", bus.dat_o, 256'hBEEF);
        bus.mem_ack_i = 1'b0;
        bus.req_i = '0;
        tick();

        // Reset while waiting for the master
        bus.req_i = 4'b0001;
        bus.adr_i[0 +: 32] = 32'h0000_0200;
        tick();
        chk("rw_gnt", bus.gnt_o, 0);
        tick();
        tick();
        rst_ni = 1'b0;
        bus.mem_ack_i = 1'b1;
        #1;
        chk("rw_busy", bus.busy_o, 0);
        chk("rw_adr", bus.mem_adr_o, 0);
        chk("rw_dat", bus.dat_o, 0);
        tick();
        chk("rw_noack", bus.ack_o, 0);
        rst_ni = 1'b1;
        bus.mem_ack_i = 1'b0;
        tick();
        chk("rw_noack2", bus.ack_o, 0);
        chk("rw_regnt", bus.gnt_o, 0);
        chk("rw_rdreq", bus.read_request_o, 1);
        tick();
        bus.mem_ack_i = 1'b1;
        tick();
        chk("rw_ack", bus.ack_o, 4'b0001);
        bus.mem_ack_i = 1'b0;
        bus.req_i = '0;
        tick();

        // Round-robin with everyone requesting
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        bus.req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            e = k % NREQ;
            found = 1'b0;
            for (int w = 0; w < 6 && !found; w++) begin
                tick();
                if (bus.read_request_o) found = 1'b1;
            end
            chk("rr_issue", found, 1);
            chk("rr_gnt", bus.gnt_o, e);
            tick();
            bus.mem_ack_i = 1'b1;
            tick();
            chk("rr_ack", bus.ack_o, 4'b0001 << e);
            chk("rr_err", bus.err_o, 0);
            bus.mem_ack_i = 1'b0;
            bus.req_i[e] = 1'b0;
            tick();
            bus.req_i[e] = 1'b1;
        end
        bus.req_i = '0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/gfx256_mem_arbiter.md
Name: gfx256_mem_arbiter

Overview:
- Shares the single 256-bit graphics bus read/write master port between NREQ graphics requesters (texture fetch, pixel read, pixel write, blitter, ...).
- Sits between the requesters and the gfx256 bus master.
- Arbitration is round-robin. Each transfer is a single request/acknowledge transaction.
- The block honours the master's post-acknowledge recovery cycle and provides a watchdog timeout.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 16'd1023, cycles in WAIT before the watchdog aborts the transfer.

Ports:
- clk_i  in  1  master clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NREQ  per-requester request level; held until that requester's ack_o
- we_i  in  NREQ  per-requester write enable (1 = write)
- adr_i  in  NREQ*32  per-requester byte address, packed as requester n at [32n+31:32n]
- sel_i  in  NREQ*32  per-requester byte lane selects
- dat_i  in  NREQ*256  per-requester write data
- ack_o  out  NREQ  one-cycle completion pulse to the granted requester
- err_o  out  NREQ  one-cycle pulse coincident with ack_o when the transfer timed out
- dat_o  out  256  read data, broadcast to all requesters; valid while ack_o is high
- read_request_o  out  1  one-cycle read request to the bus master
- write_request_o  out  1  one-cycle write request to the bus master
- mem_adr_o  out  32  address to the bus master
- mem_sel_o  out  32  lane selects to the bus master
- mem_dat_o  out  256  write data to the bus master
- mem_dat_i  in  256  read data from the bus master
- mem_ack_i  in  1  completion pulse from the bus master
- busy_o  out  1  high in any state other than IDLE
- gnt_o  out  3  index of the current or last granted requester

Behaviour:
- Reset (rst_ni low, asynchronous): state = IDLE, last = NREQ-1, gnt_o = 0.
- Also reset to 0: all ack_o, err_o, dat_o, request outputs, mem_* outputs, busy_o, and the timeout counter.
- State machine: IDLE -> ISSUE -> WAIT -> GUARD -> IDLE.
- IDLE:
  - If any req_i bit is set, grant the first set bit searching from (last+1) mod NREQ upward with wrap-around.
  - Latch that requester's we/adr/sel/dat into mem_*_o; gnt_o = last = winner; go to ISSUE.
  - Arbitration is combinational on req_i in IDLE; the grant takes effect at the next edge.
- ISSUE:
  - Exactly one cycle.
  - read_request_o = !we, write_request_o = we.
  - Counter cleared; go to WAIT.
  - mem_*_o stay stable from ISSUE through GUARD.
- WAIT:
  - Request outputs low. Counter increments each cycle.
  - On mem_ack_i: dat_o <= mem_dat_i, ack_o[gnt] <= 1 for one cycle, go to GUARD.
  - If the counter reaches TIMEOUT without mem_ack_i: ack_o[gnt] and err_o[gnt] pulse, dat_o <= 0, go to GUARD.
  - mem_ack_i and the timeout in the same cycle: the ack wins and err_o stays low.
- GUARD:
  - One idle cycle that matches the master's post-ack recovery cycle; no request is issued.
  - Go to IDLE.
- Throughput: one transfer per 3 + L cycles, where L is the master's ack latency in WAIT cycles. A new request is never issued earlier than 2 cycles after mem_ack_i.
- ack_o latency: mem_ack_i sampled at edge k gives ack_o high during cycle k+1. The requester drops req_i after seeing ack_o.
- Requester rules:
  - The arbiter re-evaluates req_i only in IDLE, which falls after GUARD, so a requester that drops req_i in the ack cycle is never re-granted.
  - A requester deasserting req_i before its ack: the transfer in flight still completes and ack_o still pulses.
- mem_ack_i while in IDLE, ISSUE or GUARD is ignored.
- Fairness: with all NREQ requesters continuously requesting, grants rotate 0,1,...,NREQ-1,0,...; no requester waits more than NREQ-1 transfers.
- Reset mid-transfer: returns to IDLE immediately. Outputs clear, no ack_o is produced, and last returns to NREQ-1.

Test Plan:
- Single read: NREQ=4, req_i=4'b0100, we=0, adr=32'h0000_1040, master acks 3 cycles after the request -> read_request_o pulses 1 cycle after the grant edge; gnt_o=2; ack_o=4'b0100 one cycle after mem_ack_i with dat_o=mem_dat_i; the next grant occurs no earlier than 2 cycles after mem_ack_i.
- Round-robin: req_i=4'b1111 held, each requester drops its req_i after its ack, then re-raises -> grant order 0,1,2,3,0; each ack_o is one-hot.
- Write pass-through: requester 1 write, sel=32'h0000_000F, dat=256'hA5 -> write_request_o pulses; mem_sel_o=32'h0000_000F and mem_dat_o=256'hA5 stable until GUARD ends.
- Timeout: TIMEOUT=8, master never acks -> ack_o[gnt] and err_o[gnt] pulse on the 8th WAIT cycle; dat_o=0; the arbiter then serves the next requester.
- Ack/timeout collision: mem_ack_i arrives on the exact timeout cycle -> ack_o pulses and err_o stays 0.
- Reset in WAIT: rst_ni low for 1 cycle -> all outputs 0, state IDLE, no ack_o; a subsequent req_i=4'b0001 is granted to 0.
